// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared types and constants for the UART receiver
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  localparam int CNT_W      = 19;
  localparam int SYNC_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_e;

  // Counter reload for a half bit (4P-1) or a full bit (8P-1).
  function automatic logic [CNT_W-1:0] count_load(input logic [15:0] p, input logic full_bit);
    logic [CNT_W-1:0] cycles;
    cycles = full_bit ? {p, 3'b000} : {1'b0, p, 2'b00};
    return cycles - CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_if : AXI-Stream style output channel of the UART receiver
// Rev 1.0
// ----------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_sync2 : two-flop synchronizer, resets to logic 1 (idle line level)
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx : 8N1-style UART receiver with AXI-Stream output and error pulses
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rxd,
  input  logic [15:0]      prescale,
  uart_rx_if.master        m_axis,
  output logic             busy,
  output logic             overrun_error,
  output logic             frame_error
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  logic                  rxd_s;
  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [15:0]           p_q;
  logic [IDX_W-1:0]      bit_idx_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  overrun_q;
  logic                  frame_err_q;
  logic [SYNC_DEPTH-1:0] prime_q;
  logic                  armed_q;
  logic [15:0]           p_eff_d;
  logic                  primed_d;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rxd),
    .q_o   (rxd_s)
  );

  assign p_eff_d  = (prescale == 16'd0) ? 16'd1 : prescale;
  // The synchronizer's reset ones are not real line samples; wait until flushed.
  assign primed_d = prime_q[SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      p_q         <= 16'd1;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      prime_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      prime_q     <= {prime_q[SYNC_DEPTH-2:0], 1'b1};
      if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (primed_d) begin
            if (!armed_q) begin
              if (rxd_s) armed_q <= 1'b1;
              else       state_q <= ST_WAIT_HIGH;
            end else if (!rxd_s) begin
              state_q <= ST_START;
              p_q     <= p_eff_d;
              cnt_q   <= count_load(p_eff_d, 1'b0);
            end
          end
        end

        ST_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rxd_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q   <= ST_DATA;
            cnt_q     <= count_load(p_q, 1'b1);
            bit_idx_q <= '0;
          end
        end

        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q <= {rxd_s, shift_q[DATA_WIDTH-1:1]};
            cnt_q   <= count_load(p_q, 1'b1);
            if (bit_idx_q == IDX_W'(DATA_WIDTH - 1)) state_q <= ST_STOP;
            else bit_idx_q <= bit_idx_q + IDX_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rxd_s) begin
            // A byte accepted on this same edge frees the slot: no overrun.
            tdata_q   <= shift_q;
            tvalid_q  <= 1'b1;
            overrun_q <= tvalid_q && !m_axis.tready;
            state_q   <= ST_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            state_q     <= ST_WAIT_HIGH;
          end
        end

        ST_WAIT_HIGH: begin
          if (rxd_s) begin
            armed_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign busy          = (state_q != ST_IDLE);
  assign overrun_error = overrun_q;
  assign frame_error   = frame_err_q;

endmodule
`default_nettype wire
